// File: rtl/gray_step_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : gray_step_monitor
//  Description : Samples a gray-coded count, converts it to binary and
//                classifies each accepted sample against the previous one
//                as hold / step-up / step-down / illegal multi-bit change.
//                Keeps a saturating error counter and a sticky error flag.
//  Revision    : 1.0  initial release
// ============================================================================
module gray_step_monitor #(
    parameter int WIDTH     = 4,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     gray_in,
    input  logic                 clear_err,
    output logic [WIDTH-1:0]     bin_out,
    output logic                 bin_valid,
    output logic                 step_up,
    output logic                 step_down,
    output logic                 hold,
    output logic                 step_err,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic                 sticky_err
);

    localparam int c_PC_W = $clog2(WIDTH + 1);

    // Binary bit i is the XOR of gray bits i..MSB.
    function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b = '0;
        for (int i = 0; i < WIDTH; i++) begin
            b[i] = ^(g >> i);
        end
        return b;
    endfunction

    // Number of set bits in a vector.
    function automatic logic [c_PC_W-1:0] popcnt(input logic [WIDTH-1:0] d);
        logic [c_PC_W-1:0] pc;
        pc = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pc = pc + {{(c_PC_W-1){1'b0}}, d[i]};
        end
        return pc;
    endfunction

    logic [WIDTH-1:0]     r_prev_gray;
    logic                 r_primed;
    logic [WIDTH-1:0]     r_bin_out;
    logic                 r_bin_valid;
    logic                 r_step_up;
    logic                 r_step_down;
    logic                 r_hold;
    logic                 r_step_err;
    logic [ERR_CNT_W-1:0] r_err_count;
    logic                 r_sticky_err;

    logic [WIDTH-1:0]     w_bin_new;
    logic [WIDTH-1:0]     w_bin_prev;
    logic [WIDTH-1:0]     w_delta;
    logic [c_PC_W-1:0]    w_popcnt;
    logic                 w_primed_acc;
    logic                 w_none;
    logic                 w_single;
    logic                 w_multi;
    logic                 w_err_evt;
    logic                 w_cnt_sat;

    // Conversion and classification of the incoming sample vs. the stored one.
    always_comb begin
        w_bin_new    = gray2bin(gray_in);
        w_bin_prev   = gray2bin(r_prev_gray);
        w_delta      = w_bin_new - w_bin_prev;
        w_popcnt     = popcnt(gray_in ^ r_prev_gray);
        w_primed_acc = in_valid & r_primed;
        w_none       = (w_popcnt == '0);
        w_single     = (w_popcnt == c_PC_W'(1));
        w_multi      = (w_popcnt >  c_PC_W'(1));
        w_err_evt    = w_primed_acc & w_multi;
        w_cnt_sat    = (r_err_count == {ERR_CNT_W{1'b1}});
    end

    // Sample tracking, binary output and one-cycle classification pulses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_prev_gray <= '0;
            r_primed    <= 1'b0;
            r_bin_out   <= '0;
            r_bin_valid <= 1'b0;
            r_step_up   <= 1'b0;
            r_step_down <= 1'b0;
            r_hold      <= 1'b0;
            r_step_err  <= 1'b0;
        end else begin
            r_bin_valid <= in_valid;
            r_hold      <= w_primed_acc & w_none;
            r_step_up   <= w_primed_acc & w_single & (w_delta == WIDTH'(1));
            r_step_down <= w_primed_acc & w_single & (w_delta != WIDTH'(1));
            r_step_err  <= w_err_evt;
            if (in_valid) begin
                // Illegal samples also become the new reference (resync).
                r_prev_gray <= gray_in;
                r_bin_out   <= w_bin_new;
                r_primed    <= 1'b1;
            end
        end
    end

    // Saturating error counter and sticky flag; a new error beats a clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_err_count  <= '0;
            r_sticky_err <= 1'b0;
        end else if (w_err_evt) begin
            r_sticky_err <= 1'b1;
            if (clear_err) begin
                r_err_count <= ERR_CNT_W'(1);
            end else if (!w_cnt_sat) begin
                r_err_count <= r_err_count + ERR_CNT_W'(1);
            end
        end else if (clear_err) begin
            r_err_count  <= '0;
            r_sticky_err <= 1'b0;
        end
    end

    assign bin_out    = r_bin_out;
    assign bin_valid  = r_bin_valid;
    assign step_up    = r_step_up;
    assign step_down  = r_step_down;
    assign hold       = r_hold;
    assign step_err   = r_step_err;
    assign err_count  = r_err_count;
    assign sticky_err = r_sticky_err;

endmodule
`default_nettype wire

// File: doc/gray_step_monitor.md
Name: gray_step_monitor

Overview:
Downstream consumer of the 4-bit gray counter output. Samples a gray-coded count each valid cycle, converts it to binary and classifies each transition against the previously accepted sample as hold, step-up, step-down or illegal multi-bit change. Keeps a saturating error count and a sticky error flag for debug and status readout. Single clock domain, registered outputs.

Parameters:
WIDTH, 4, width of gray input and binary output
ERR_CNT_W, 8, width of saturating illegal-step counter

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
in_valid  input  1  gray_in is sampled on this cycle
gray_in  input  WIDTH  gray-coded count from upstream counter
clear_err  input  1  synchronous clear of err_count and sticky_err
bin_out  output  WIDTH  binary equivalent of last accepted gray_in
bin_valid  output  1  one-cycle pulse: bin_out updated
step_up  output  1  one-cycle pulse: accepted sample is previous +1 (mod 2^WIDTH)
step_down  output  1  one-cycle pulse: accepted sample is previous -1 (mod 2^WIDTH)
hold  output  1  one-cycle pulse: accepted sample equals previous
step_err  output  1  one-cycle pulse: more than one bit changed
err_count  output  ERR_CNT_W  saturating count of step_err events
sticky_err  output  1  set on any step_err, held until clear_err or reset

Behaviour:
- Reset (reset_n low, asynchronous): all outputs 0; stored previous gray 0; primed flag 0.
- Conversion: b[WIDTH-1]=g[WIDTH-1]; b[i]=b[i+1]^g[i] for i down to 0.
- Latency 1: gray_in accepted at edge N when in_valid=1; bin_out, bin_valid and classification pulses visible after edge N, for exactly one cycle (pulses). bin_out holds its value between accepts.
- in_valid=0: bin_valid, step_up, step_down, hold, step_err all 0; stored state unchanged.
- Primed flag: first accepted sample after reset sets primed=1, drives bin_valid=1, all classification pulses 0, no error counting.
- Classification (primed=1): d = gray_in XOR prev_gray.
  - popcount(d)=0 -> hold=1.
  - popcount(d)=1 -> binary delta (b_new - b_prev) mod 2^WIDTH; delta=1 -> step_up=1; delta=2^WIDTH-1 -> step_down=1 (these are the only possibilities).
  - popcount(d)>=2 -> step_err=1, err_count+1, sticky_err=1.
  - Exactly one of hold/step_up/step_down/step_err high per primed accept.
- prev_gray updated to gray_in on every accept, including illegal ones (resynchronise on new value).
- Wrap-around: gray 1000 (bin 15) -> 0000 (bin 0) is step_up; reverse is step_down.
- err_count saturates at 2^ERR_CNT_W-1; further errors keep sticky_err=1 and pulse step_err but do not wrap count.
- clear_err: sets err_count=0, sticky_err=0 on next edge. If clear_err and a new step_err occur on same edge: err_count=1, sticky_err=1 (new event wins).
- Reset mid-stream: primed cleared; next accept treated as first sample (no error regardless of value).

Test Plan:
- Reset release, feed in_valid=1 with gray 0000,0000,0001,0011,0010 -> bin_out 0,0,1,2,3; first pulse bin_valid only, then hold, step_up x3.
- Full up-cycle of 16 gray codes through 1000 -> 0000 -> step_up every cycle including wrap, err_count stays 0.
- Descending sequence 0000,1000,1001,1011 -> bin 0,15,14,13; step_down on each primed accept.
- Inject 0001 -> 0111 (two bits differ) -> step_err=1, err_count=1, sticky_err=1, bin_out=5; following 0101 -> step_down, bin_out=6? no: 0101 = bin 6 from 5 -> step_up, count unchanged.
- ERR_CNT_W=2, 5 illegal steps -> err_count saturates at 3; clear_err alone -> 0/0; clear_err coincident with step_err -> err_count=1, sticky_err=1.
- Assert reset_n low mid-stream after 0011, release, feed 1100 -> bin_valid=1, bin_out=8, no step_err, err_count 0; in_valid gaps produce no pulses and bin_out holds.
